// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: protocol byte constants and the command
// scheduler's state encoding.
package ps2_pkg;

  localparam logic [7:0] CMD_EN_REPORTING = 8'hF4;
  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] RSP_ACK          = 8'hFA;
  localparam logic [7:0] RSP_RESEND       = 8'hFE;
  localparam logic [7:0] RSP_ERROR        = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK       = 8'hAA;
  localparam logic [7:0] MOUSE_ID         = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BUSY = 3'd1,
    S_WRITE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_DONE      = 3'd4
  } sched_state_e;

  // Bytes the scheduler consumes itself while waiting for a command reply.
  function automatic logic is_handshake(input logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_ERROR);
  endfunction

endpackage

// File: rtl/ps2_cmd_scheduler_if.sv
// Bundle of requester, transmitter, receiver and forwarding signals around
// the PS/2 command scheduler.
//
// Handshakes: req is a level held by a requester until its one-cycle done or
// fail pulse; write is a one-cycle strobe issued only while busy is low;
// rx_valid and fwd_valid are one-cycle strobes qualifying their data bytes.
interface ps2_cmd_scheduler_if;
  logic [1:0] req;
  logic [7:0] cmd0;
  logic [7:0] cmd1;
  logic [1:0] done;
  logic [1:0] fail;
  logic       owner;
  logic       active;
  logic [7:0] tx_data;
  logic       write;
  logic       busy;
  logic       tx_err;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] fwd_byte;
  logic       fwd_valid;

  modport master (
    input  req, cmd0, cmd1, busy, tx_err, rx_byte, rx_valid, rx_err,
    output done, fail, owner, active, tx_data, write, fwd_byte, fwd_valid
  );

  modport slave (
    output req, cmd0, cmd1, busy, tx_err, rx_byte, rx_valid, rx_err,
    input  done, fail, owner, active, tx_data, write, fwd_byte, fwd_valid
  );
endinterface

// File: rtl/ps2_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module ps2_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       grant,
  output logic       grant_valid
);

  // Pick a winner from the request vector and the previous winner.
  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    if (req == 2'b11) grant = ~last_served;
    else if (req[1])  grant = 1'b1;
  end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Shares one PS/2 host transmitter between two command requesters, handles
// resend/error replies with bounded retries and a reply timeout, and forwards
// all non-handshake received bytes to the mouse packet path.
module ps2_cmd_scheduler
  import ps2_pkg::*;
#(
  parameter  int ACK_TIMEOUT = 500000,
  parameter  int MAX_RETRY   = 3,
  localparam int TW          = $clog2(ACK_TIMEOUT),
  localparam int RW          = $clog2(MAX_RETRY + 1)
) (
  input  logic                 clk_25MHz,
  input  logic                 reset,
  ps2_cmd_scheduler_if.master  bus,
  output sched_state_e         state_dbg,
  output logic [RW-1:0]        retry_dbg
);

  sched_state_e   state, state_n;
  logic [7:0]     tx_data_q;
  logic           owner_q;
  logic           last_served_q;
  logic           ok_q;
  logic [RW-1:0]  retry_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           grant, grant_valid;
  logic           tmo_hit;
  logic           resend_ev;
  logic           retry_inc;
  logic           set_ok;
  logic           set_fail;
  logic           fwd_take;

  ps2_rr_arbiter u_arb (
    .req         (bus.req),
    .last_served (last_served_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign tmo_hit = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

  // State register; reset drops any transaction in flight without a pulse.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode and reply classification in WAIT_ACK.
  // Priority within one cycle: received byte, rx_err, tx_err, timeout.
  always_comb begin
    state_n   = state;
    resend_ev = 1'b0;
    retry_inc = 1'b0;
    set_ok    = 1'b0;
    set_fail  = 1'b0;
    case (state)
      S_IDLE:      if (grant_valid) state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.busy) state_n = S_WRITE;
      S_WRITE:     state_n = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == RSP_ACK) begin
            state_n = S_DONE;
            set_ok  = 1'b1;
          end else if (bus.rx_byte == RSP_ERROR) begin
            state_n  = S_DONE;
            set_fail = 1'b1;
          end else if (bus.rx_byte == RSP_RESEND) begin
            resend_ev = 1'b1;
          end
        end else if (bus.rx_err || bus.tx_err || tmo_hit) begin
          resend_ev = 1'b1;
        end
        if (resend_ev) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            state_n   = S_WAIT_BUSY;
            retry_inc = 1'b1;
          end else begin
            state_n  = S_DONE;
            set_fail = 1'b1;
          end
        end
      end
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Transaction context: grant, command byte, retries, outcome, fairness.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      tx_data_q     <= 8'h00;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      ok_q          <= 1'b0;
      retry_cnt     <= '0;
    end else begin
      if (state == S_IDLE && grant_valid) begin
        owner_q   <= grant;
        tx_data_q <= grant ? bus.cmd1 : bus.cmd0;
        retry_cnt <= '0;
      end
      if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
      if (set_ok)    ok_q <= 1'b1;
      if (set_fail)  ok_q <= 1'b0;
      if (state == S_DONE) last_served_q <= owner_q;
    end
  end

  // Reply timeout: restarted by each write, saturating at its limit.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset)                              tmo_cnt <= '0;
    else if (state == S_WRITE)              tmo_cnt <= '0;
    else if (state == S_WAIT_ACK && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign fwd_take = bus.rx_valid &&
                    !(state == S_WAIT_ACK && is_handshake(bus.rx_byte));

  // Forward received bytes one cycle later unless consumed as a reply.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      bus.fwd_valid <= 1'b0;
      bus.fwd_byte  <= 8'h00;
    end else begin
      bus.fwd_valid <= fwd_take;
      if (fwd_take) bus.fwd_byte <= bus.rx_byte;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.owner   = owner_q;
  assign bus.write   = (state == S_WRITE);
  assign bus.active  = (state != S_IDLE);
  assign bus.done    = (state == S_DONE &&  ok_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.fail    = (state == S_DONE && !ok_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign state_dbg   = state;
  assign retry_dbg   = retry_cnt;

endmodule

// File: doc/ps2_cmd_scheduler.md
# ps2_cmd_scheduler

Shares the single PS/2 host transmitter between two command requesters: requester 0 is the mouse init/control FSM, requester 1 is the config/debug port. Grants are round-robin. For each command the block waits for the transmitter to go idle, issues one write, then waits for the device response byte. It handles resend and error responses with bounded retries and a timeout, and forwards every non-handshake received byte to the mouse packet path.

## Interface
Parameters:
- ACK_TIMEOUT, 500000: clk_25MHz cycles allowed in WAIT_ACK (20 ms).
- MAX_RETRY, 3: retransmissions allowed after the first attempt.

Ports:
- clk_25MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req  in  2  per-requester command request; held until that requester's done or fail.
- cmd0, cmd1  in  8  command byte per requester; stable while req is high.
- done  out  2  one-cycle pulse: command acknowledged (0xFA).
- fail  out  2  one-cycle pulse: retries exhausted, or 0xFC received.
- owner  out  1  index of the granted requester.
- active  out  1  high from grant through DONE.
- tx_data  out  8  byte to the PS/2 transmitter.
- write  out  1  one-cycle transmit strobe.
- busy  in  1  transmitter busy.
- tx_err  in  1  transmitter error pulse.
- rx_byte  in  8  received data byte (start, stop and parity already stripped).
- rx_valid  in  1  one-cycle received-byte strobe.
- rx_err  in  1  receive framing/parity error pulse.
- fwd_byte  out  8  forwarded received byte.
- fwd_valid  out  1  forwarded-byte strobe.

## Operation
- States: IDLE, WAIT_BUSY, WRITE, WAIT_ACK, DONE.
- IDLE:
  - Any req high → register the grant, latch the granted cmd into tx_data, clear retry_cnt → WAIT_BUSY.
  - Round-robin: if both requesters are requesting, the one not served last wins. last_served resets to 1, so requester 0 wins the first contention.
- WAIT_BUSY: busy=0 → WRITE; otherwise stay.
- WRITE: write=1 for this cycle only → WAIT_ACK; clear the timeout counter.
- WAIT_ACK (ignores busy):
  - rx_valid with 0xFA → DONE, outcome ok.
  - rx_valid with 0xFC → DONE, outcome fail.
  - Resend event → WAIT_BUSY with retry_cnt+1 if retry_cnt<MAX_RETRY; otherwise DONE, outcome fail. Resend events are:
    - rx_valid with 0xFE,
    - rx_err,
    - tx_err,
    - timeout counter reaching ACK_TIMEOUT-1.
  - rx_valid with any other byte → forwarded; the block stays in WAIT_ACK.
- DONE: pulse done[owner] or fail[owner] → IDLE; update last_served.
- Forwarding:
  - In every state except WAIT_ACK, each rx_valid is forwarded.
  - In WAIT_ACK, 0xFA, 0xFE and 0xFC are consumed, not forwarded.
- A requester dropping req mid-transaction does not abort it; the done/fail pulse is still produced.
- Event priority in one WAIT_ACK cycle: rx_valid byte, then rx_err, then tx_err, then timeout.
- Reset mid-transaction: return to IDLE immediately; no done/fail is issued; the requester must re-request.

## Timing
- Reset values:
  - write=0, tx_data=0x00, done=0, fail=0, owner=0, active=0, fwd_valid=0, fwd_byte=0x00
  - state=IDLE, retry_cnt=0, last_served=1, timeout counter=0
- All outputs are registered or Moore-decoded from state; no combinational path from input to output.
- Minimum latency:
  - req sampled high at edge N → WAIT_BUSY.
  - busy low at N+1 → write high for cycle N+2.
  - ACK rx_valid at edge M → done high for exactly one cycle after M.
  - IDLE at M+2; a new grant is possible at the following edge.
- fwd_valid/fwd_byte: one cycle after rx_valid.
- tx_data is stable from WAIT_BUSY entry until IDLE.
- Timeout counter width: clog2(ACK_TIMEOUT); it saturates and does not wrap.
- retry_cnt width: clog2(MAX_RETRY+1).

## Structure
- Shared package ps2_pkg holds:
  - PS/2 byte constants: CMD_EN_REPORTING 0xF4, CMD_RESET 0xFF, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_ERROR 0xFC, RSP_BAT_OK 0xAA, MOUSE_ID 0x00.
  - Scheduler state encoding.
- Sub-module ps2_rr_arbiter: 2-way round-robin grant logic (req, last_served → grant index, grant valid).

## Test plan
- Single request: req=01, cmd0=0xF4, busy low, ACK 0xFA 100 cycles after write → one write pulse with tx_data=0xF4, done=01 pulse, fail=00, fwd_valid never high.
- Contention: req=11 from reset → requester 0 served first (owner=0), then requester 1 (owner=1); each gets exactly one done pulse.
- Resend: reply 0xFE twice, then 0xFA → three write pulses, done pulse, retry_cnt returns 0 on the next grant.
- Exhaustion: reply 0xFE four times with MAX_RETRY=3 → four writes, then a fail pulse; a reply of 0xFC → immediate fail with no extra write.
- Timeout plus forwarding: ACK_TIMEOUT=50, no reply → retransmission after 50 cycles; a 0x08 received in WAIT_ACK is forwarded (fwd_byte=0x08) while the state is held.
- Reset asserted in WAIT_ACK → all outputs at reset values within the same cycle; no done/fail; a fresh request is then served normally.
